// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Purpose  : Signal bundle between the pipeline datapath and the central
//            stall/flush controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    // hazard-detection inputs to the controller
    logic        ihit;
    logic        dhit;
    logic        mem_req_MEM;
    logic        load_ID_EX;
    logic [4:0]  Rt_ID_EX;
    logic [4:0]  Rs_IF_ID;
    logic [4:0]  Rt_IF_ID;
    logic        uses_rt_IF_ID;
    logic        redirect_MEM;
    logic [31:0] target_MEM;
    logic        halt_MEM_WB;

    // pipeline control outputs
    logic        pc_en;
    logic        pc_sel_redirect;
    logic [31:0] redirect_pc;
    logic        enable_IF_ID;
    logic        enable_ID_EX;
    logic        enable_EX_MEM;
    logic        enable_MEM_WB;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic        flush_EX_MEM;
    logic        flush_MEM_WB;
    logic        halt;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    // datapath side: drives hazard information, receives control
    modport master (
        output ihit, dhit, mem_req_MEM, load_ID_EX, Rt_ID_EX, Rs_IF_ID,
               Rt_IF_ID, uses_rt_IF_ID, redirect_MEM, target_MEM, halt_MEM_WB,
        input  pc_en, pc_sel_redirect, redirect_pc,
               enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               halt, stall_cycles, flush_events
    );

    // controller side
    modport slave (
        input  ihit, dhit, mem_req_MEM, load_ID_EX, Rt_ID_EX, Rs_IF_ID,
               Rt_IF_ID, uses_rt_IF_ID, redirect_MEM, target_MEM, halt_MEM_WB,
        output pc_en, pc_sel_redirect, redirect_pc,
               enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               halt, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush controller for the five-stage pipeline.
//            Decides per cycle whether PC and each pipeline register load,
//            hold or take a bubble; holds a redirect target across an
//            instruction-fetch miss; keeps saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl (
    input  wire logic             CLK,
    input  wire logic             nRST,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_WAIT = 2'd1,
        HALT       = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state;
    state_t      state_next;
    logic [31:0] tgt_q;
    logic [31:0] tgt_next;
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic        stall_inc;
    logic        flush_inc;
    logic        dfreeze;
    logic        load_use;

    // A data miss in MEM freezes the whole pipeline, redirects included.
    assign dfreeze = bus.mem_req_MEM & ~bus.dhit;

    // Loaded value would be consumed by the very next instruction; $zero never hazards.
    assign load_use = bus.load_ID_EX && (bus.Rt_ID_EX != 5'd0) &&
                      ((bus.Rt_ID_EX == bus.Rs_IF_ID) ||
                       (bus.uses_rt_IF_ID && (bus.Rt_ID_EX == bus.Rt_IF_ID)));

    // State, latched redirect target and saturating counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= RUN;
            tgt_q   <= 32'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state <= state_next;
            tgt_q <= tgt_next;
            if (stall_inc && (stall_q != CNT_MAX))
                stall_q <= stall_q + 16'd1;
            if (flush_inc && (flush_q != CNT_MAX))
                flush_q <= flush_q + 16'd1;
        end
    end

    // Priority-ordered hazard resolution; everything here is same-cycle control.
    always_comb begin
        bus.pc_en           = 1'b1;
        bus.pc_sel_redirect = 1'b0;
        bus.redirect_pc     = bus.target_MEM;
        bus.enable_IF_ID    = 1'b1;
        bus.enable_ID_EX    = 1'b1;
        bus.enable_EX_MEM   = 1'b1;
        bus.enable_MEM_WB   = 1'b1;
        bus.flush_IF_ID     = 1'b0;
        bus.flush_ID_EX     = 1'b0;
        bus.flush_EX_MEM    = 1'b0;
        bus.flush_MEM_WB    = 1'b0;
        bus.halt            = 1'b0;
        state_next          = state;
        tgt_next            = tgt_q;
        stall_inc           = 1'b0;
        flush_inc           = 1'b0;

        if (!nRST) begin
            // Hold every stage cleared while in reset.
            bus.pc_en         = 1'b0;
            bus.redirect_pc   = 32'd0;
            bus.enable_IF_ID  = 1'b0;
            bus.enable_ID_EX  = 1'b0;
            bus.enable_EX_MEM = 1'b0;
            bus.enable_MEM_WB = 1'b0;
            bus.flush_IF_ID   = 1'b1;
            bus.flush_ID_EX   = 1'b1;
            bus.flush_EX_MEM  = 1'b1;
            bus.flush_MEM_WB  = 1'b1;
            state_next        = RUN;
            tgt_next          = 32'd0;
        end else if ((state == HALT) || bus.halt_MEM_WB) begin
            bus.pc_en         = 1'b0;
            bus.enable_IF_ID  = 1'b0;
            bus.enable_ID_EX  = 1'b0;
            bus.enable_EX_MEM = 1'b0;
            bus.enable_MEM_WB = 1'b0;
            bus.halt          = (state == HALT);
            state_next        = HALT;
        end else if (dfreeze) begin
            bus.pc_en         = 1'b0;
            bus.enable_IF_ID  = 1'b0;
            bus.enable_ID_EX  = 1'b0;
            bus.enable_EX_MEM = 1'b0;
            bus.enable_MEM_WB = 1'b0;
            stall_inc         = 1'b1;
        end else if (state == REDIR_WAIT) begin
            // Keep steering fetch to the latched target until it hits.
            bus.flush_IF_ID     = 1'b1;
            bus.pc_sel_redirect = 1'b1;
            bus.redirect_pc     = tgt_q;
            bus.pc_en           = bus.ihit;
            if (bus.ihit)
                state_next = RUN;
            else
                stall_inc = 1'b1;
        end else if (bus.redirect_MEM) begin
            // Squash the three younger wrong-path instructions.
            bus.flush_IF_ID  = 1'b1;
            bus.flush_ID_EX  = 1'b1;
            bus.flush_EX_MEM = 1'b1;
            flush_inc        = 1'b1;
            if (bus.ihit) begin
                bus.pc_sel_redirect = 1'b1;
            end else begin
                bus.pc_en  = 1'b0;
                tgt_next   = bus.target_MEM;
                state_next = REDIR_WAIT;
            end
        end else if (load_use) begin
            bus.pc_en        = 1'b0;
            bus.enable_IF_ID = 1'b0;
            bus.flush_ID_EX  = 1'b1;
            stall_inc        = 1'b1;
        end else if (!bus.ihit) begin
            bus.pc_en       = 1'b0;
            bus.flush_IF_ID = 1'b1;
            stall_inc       = 1'b1;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl: directed scenarios
//            with literal expectations plus randomized traffic, all checked
//            every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic CLK;
    logic nRST;
    int   checks;
    int   failures;
    bit   chk_on;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // control vector: {pc_en, pc_sel, en IF/ID..MEM/WB, flush IF/ID..MEM/WB, halt}
    localparam logic [10:0] V_RESET  = 11'b0_0_0000_1111_0;
    localparam logic [10:0] V_IDLE   = 11'b1_0_1111_0000_0;
    localparam logic [10:0] V_LDUSE  = 11'b0_0_0111_0100_0;
    localparam logic [10:0] V_FREEZE = 11'b0_0_0000_0000_0;
    localparam logic [10:0] V_RDHIT  = 11'b1_1_1111_1110_0;
    localparam logic [10:0] V_RDMISS = 11'b0_0_1111_1110_0;
    localparam logic [10:0] V_WMISS  = 11'b0_1_1111_1000_0;
    localparam logic [10:0] V_WHIT   = 11'b1_1_1111_1000_0;
    localparam logic [10:0] V_HALTED = 11'b0_0_0000_0000_1;

    function automatic logic [10:0] ctrl_vec();
        return {bus.pc_en, bus.pc_sel_redirect,
                bus.enable_IF_ID, bus.enable_ID_EX, bus.enable_EX_MEM, bus.enable_MEM_WB,
                bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM, bus.flush_MEM_WB,
                bus.halt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 = running, 1 = waiting for fetch at redirect target, 2 = halted
    int          m_mode;
    logic [31:0] m_tgt;
    int          m_stall;
    int          m_flush;

    always @(negedge CLK) begin
        if (chk_on) begin
            logic [10:0] e;
            logic [31:0] rpc;
            int          nmode;
            logic [31:0] ntgt;
            bit          s_inc, f_inc;
            bit          pc, sel, halted;
            bit [3:0]    en, fl;
            bit          hazard;
            nmode = m_mode; ntgt = m_tgt; s_inc = 0; f_inc = 0;
            pc = 1; sel = 0; en = 4'hF; fl = 4'h0; halted = 0;
            rpc = bus.target_MEM;
            hazard = bus.load_ID_EX && bus.Rt_ID_EX != 0 &&
                     (bus.Rt_ID_EX == bus.Rs_IF_ID ||
                      (bus.uses_rt_IF_ID && bus.Rt_ID_EX == bus.Rt_IF_ID));
            if (!nRST) begin
                pc = 0; en = 4'h0; fl = 4'hF; rpc = 0;
                nmode = 0; ntgt = 0;
            end else if (m_mode == 2 || bus.halt_MEM_WB) begin
                pc = 0; en = 4'h0; halted = (m_mode == 2); nmode = 2;
            end else if (bus.mem_req_MEM && !bus.dhit) begin
                pc = 0; en = 4'h0; s_inc = 1;
            end else if (m_mode == 1) begin
                fl = 4'b1000; sel = 1; rpc = m_tgt; pc = bus.ihit;
                if (bus.ihit) nmode = 0; else s_inc = 1;
            end else if (bus.redirect_MEM) begin
                fl = 4'b1110; f_inc = 1;
                if (bus.ihit) sel = 1;
                else begin pc = 0; ntgt = bus.target_MEM; nmode = 1; end
            end else if (hazard) begin
                pc = 0; en = 4'b0111; fl = 4'b0100; s_inc = 1;
            end else if (!bus.ihit) begin
                pc = 0; fl = 4'b1000; s_inc = 1;
            end
            e = {pc, sel, en, fl, halted};
            chk("ctrl_vector", {21'd0, ctrl_vec()}, {21'd0, e});
            chk("redirect_pc", bus.redirect_pc, rpc);
            chk("stall_cycles", {16'd0, bus.stall_cycles}, m_stall);
            chk("flush_events", {16'd0, bus.flush_events}, m_flush);
            if (!nRST) begin
                m_stall = 0; m_flush = 0;
            end else begin
                m_stall = (s_inc && m_stall < 65535) ? m_stall + 1 : m_stall;
                m_flush = (f_inc && m_flush < 65535) ? m_flush + 1 : m_flush;
            end
            m_mode = nmode;
            m_tgt  = ntgt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input bit ih);
        bus.ihit = ih; bus.dhit = 1'b1; bus.mem_req_MEM = 1'b0;
        bus.load_ID_EX = 1'b0; bus.Rt_ID_EX = 5'd0; bus.Rs_IF_ID = 5'd0;
        bus.Rt_IF_ID = 5'd0; bus.uses_rt_IF_ID = 1'b0; bus.redirect_MEM = 1'b0;
        bus.target_MEM = 32'd0; bus.halt_MEM_WB = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle(1'b1);
        repeat (2) next_cycle();
        nRST = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; chk_on = 0;
        m_mode = 0; m_tgt = 0; m_stall = 0; m_flush = 0;
        nRST = 1'b0;
        idle(1'b1);
        next_cycle();
        chk_on = 1;

        // reset: outputs forced while asserted
        @(negedge CLK);
        chk("reset_ctrl", {21'd0, ctrl_vec()}, {21'd0, V_RESET});
        chk("reset_rpc", bus.redirect_pc, 32'd0);
        chk("reset_stall", {16'd0, bus.stall_cycles}, 32'd0);
        next_cycle();
        nRST = 1'b1;
        idle(1'b1);
        @(negedge CLK);
        chk("post_reset_run", {21'd0, ctrl_vec()}, {21'd0, V_IDLE});

        // load-use: one-cycle stall
        next_cycle();
        bus.load_ID_EX = 1'b1; bus.Rt_ID_EX = 5'd5; bus.Rs_IF_ID = 5'd5;
        @(negedge CLK);
        chk("load_use_ctrl", {21'd0, ctrl_vec()}, {21'd0, V_LDUSE});
        next_cycle();
        idle(1'b1);
        @(negedge CLK);
        chk("load_use_over", {21'd0, ctrl_vec()}, {21'd0, V_IDLE});
        chk("load_use_stall", {16'd0, bus.stall_cycles}, 32'd1);
        next_cycle();
        bus.load_ID_EX = 1'b1; bus.Rt_ID_EX = 5'd0; bus.Rs_IF_ID = 5'd0;
        @(negedge CLK);
        chk("load_r0_nostall", {21'd0, ctrl_vec()}, {21'd0, V_IDLE});

        // data miss freezes a pending redirect
        next_cycle();
        do_reset();
        bus.mem_req_MEM = 1'b1; bus.dhit = 1'b0; bus.redirect_MEM = 1'b1;
        bus.target_MEM = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("dmiss_freeze", {21'd0, ctrl_vec()}, {21'd0, V_FREEZE});
            next_cycle();
        end
        bus.dhit = 1'b1;
        @(negedge CLK);
        chk("dmiss_release", {21'd0, ctrl_vec()}, {21'd0, V_RDHIT});
        chk("dmiss_stall", {16'd0, bus.stall_cycles}, 32'd4);
        next_cycle();
        idle(1'b1);
        @(negedge CLK);
        chk("dmiss_flush_events", {16'd0, bus.flush_events}, 32'd1);

        // redirect during an instruction miss
        next_cycle();
        do_reset();
        idle(1'b0);
        bus.redirect_MEM = 1'b1; bus.target_MEM = 32'h0000_0040;
        @(negedge CLK);
        chk("redir_miss_ctrl", {21'd0, ctrl_vec()}, {21'd0, V_RDMISS});
        chk("redir_miss_rpc", bus.redirect_pc, 32'h40);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.redirect_MEM = 1'b0; bus.target_MEM = 32'hDEAD_BEEF;
            @(negedge CLK);
            chk("redir_wait_ctrl", {21'd0, ctrl_vec()}, {21'd0, V_WMISS});
            chk("redir_wait_rpc", bus.redirect_pc, 32'h40);
        end
        next_cycle();
        bus.ihit = 1'b1;
        @(negedge CLK);
        chk("redir_wait_hit", {21'd0, ctrl_vec()}, {21'd0, V_WHIT});
        chk("redir_wait_hit_rpc", bus.redirect_pc, 32'h40);
        next_cycle();
        idle(1'b1);
        @(negedge CLK);
        chk("redir_back_run", {21'd0, ctrl_vec()}, {21'd0, V_IDLE});
        chk("redir_stall", {16'd0, bus.stall_cycles}, 32'd2);

        // halt is sticky
        next_cycle();
        do_reset();
        bus.halt_MEM_WB = 1'b1;
        @(negedge CLK);
        chk("halt_enter", {21'd0, ctrl_vec()}, {21'd0, V_FREEZE});
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.halt_MEM_WB = 1'b0;
            bus.redirect_MEM = 1'($urandom_range(0, 1));
            bus.ihit = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("halt_sticky", {21'd0, ctrl_vec()}, {21'd0, V_HALTED});
        end

        // stall counter saturation
        next_cycle();
        do_reset();
        idle(1'b0);
        repeat (70000) next_cycle();
        @(negedge CLK);
        chk("stall_saturate", {16'd0, bus.stall_cycles}, 32'h0000_FFFF);

        // randomized traffic
        next_cycle();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            nRST                = ($urandom_range(0, 49) != 0);
            bus.ihit            = ($urandom_range(0, 3) != 0);
            bus.dhit            = ($urandom_range(0, 9) < 7);
            bus.mem_req_MEM     = ($urandom_range(0, 9) < 4);
            bus.load_ID_EX      = ($urandom_range(0, 9) < 3);
            bus.Rt_ID_EX        = 5'($urandom_range(0, 7));
            bus.Rs_IF_ID        = 5'($urandom_range(0, 7));
            bus.Rt_IF_ID        = 5'($urandom_range(0, 7));
            bus.uses_rt_IF_ID   = 1'($urandom_range(0, 1));
            bus.redirect_MEM    = ($urandom_range(0, 19) < 3);
            bus.target_MEM      = $urandom;
            bus.halt_MEM_WB     = ($urandom_range(0, 199) == 0);
            next_cycle();
        end

        @(negedge CLK);
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. Each cycle it decides whether the PC and each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold, or load a bubble. The decision depends on instruction/data memory readiness, load-use hazards, control-flow redirects resolved in MEM, and halt. It also latches a pending redirect target across an instruction-fetch miss and keeps saturating stall and flush event counters.

## Interface
Parameters: none.

- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  synchronous, active-low reset
- ihit  in  1  instruction word for the current PC is valid this cycle
- dhit  in  1  data memory access in MEM completes this cycle
- mem_req_MEM  in  1  EX/MEM holds a load or store (dREN|dWEN)
- load_ID_EX  in  1  ID/EX holds a load
- Rt_ID_EX  in  5  load destination register
- Rs_IF_ID, Rt_IF_ID  in  5 each  source registers of the instruction in IF/ID
- uses_rt_IF_ID  in  1  the instruction in IF/ID reads Rt
- redirect_MEM  in  1  taken branch or jump resolved in MEM
- target_MEM  in  32  redirect target
- halt_MEM_WB  in  1  halt instruction in MEM/WB
- pc_en  out  1  PC loads its next value
- pc_sel_redirect  out  1  next PC = redirect_pc (else PC+4)
- redirect_pc  out  32  redirect target
- enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  register loads
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  register clears to bubble at the edge; dominates enable
- halt  out  1  processor halted
- stall_cycles  out  16  saturating count of stall cycles
- flush_events  out  16  saturating count of redirects

## Operation
- States: RUN, REDIR_WAIT, HALT. Register: tgt_q[31:0].
- Outputs are combinational from state and inputs. Default: all enables 1, all flushes 0, pc_en 1, pc_sel_redirect 0, redirect_pc = target_MEM.
- Priority per cycle, first match wins:
  1. **HALT state or halt_MEM_WB.** All enables 0, pc_en 0, flushes 0. halt = 1 in HALT only. Next state is HALT, which is sticky until reset.
  2. **dfreeze = mem_req_MEM & !dhit.** All enables 0, flushes 0, pc_en 0. ihit is ignored. stall_cycles increments. The state is unchanged, and any redirect is preserved because the stages are frozen.
  3. **REDIR_WAIT.** flush_IF_ID = 1, pc_sel_redirect = 1, redirect_pc = tgt_q, pc_en = ihit. On ihit, go to RUN; otherwise stall_cycles increments.
  4. **redirect_MEM (RUN).** flush_IF_ID = flush_ID_EX = flush_EX_MEM = 1. flush_events increments.
     - If ihit: pc_en = 1, pc_sel_redirect = 1.
     - If !ihit: pc_en = 0, tgt_q <= target_MEM, go to REDIR_WAIT.
  5. **Load-use.** Condition: load_ID_EX & Rt_ID_EX != 0 & (Rt_ID_EX == Rs_IF_ID | (uses_rt_IF_ID & Rt_ID_EX == Rt_IF_ID)). Action: pc_en 0, enable_IF_ID 0, flush_ID_EX 1. stall_cycles increments.
  6. **!ihit.** pc_en 0, flush_IF_ID 1. stall_cycles increments.
  7. **Otherwise.** Defaults apply.
- Counters saturate at 16'hFFFF.

## Timing
- While nRST = 0 at an edge: state <= RUN, tgt_q <= 0, counters <= 0.
- While nRST = 0, outputs are forced to: enables 0, all flushes 1, pc_en 0, pc_sel_redirect 0, redirect_pc 0, halt 0. Reset asserted mid-stall or in REDIR_WAIT discards tgt_q.
- Zero-latency control: decisions take effect at the same edge on which the inputs are sampled.
- A load-use stall lasts exactly 1 cycle, because the load advances into EX/MEM and the hazard clears.
- A redirect costs 3 bubbles plus 1 extra cycle per miss cycle in REDIR_WAIT.
- Halt is visible on halt one cycle after halt_MEM_WB is sampled.
- Flushes are never asserted during dfreeze, so frozen contents are preserved.

## Test plan
- **Reset.** nRST = 0 for 2 cycles -> outputs forced as specified, counters 0. First cycle after release with ihit = 1 -> pc_en 1, all enables 1.
- **Load-use.** load_ID_EX = 1, Rt_ID_EX = 5, Rs_IF_ID = 5 -> one cycle of pc_en 0, enable_IF_ID 0, flush_ID_EX 1; stall_cycles = 1. Repeating with Rt_ID_EX = 0 -> no stall.
- **Data miss.** mem_req_MEM = 1, dhit = 0 for 4 cycles while redirect_MEM = 1 -> all enables 0, no flushes for 4 cycles. When dhit = 1 with ihit = 1 -> 3 flushes, pc_sel_redirect 1, stall_cycles = 4, flush_events = 1.
- **Redirect on miss.** redirect_MEM = 1, target_MEM = 0x0000_0040, ihit = 0, then ihit = 0 for 2 more cycles, then ihit = 1 -> redirect_pc = 0x40 throughout; pc_en rises only on the ihit cycle; flush_IF_ID 1 for all 4 cycles; state back in RUN.
- **Halt.** halt_MEM_WB = 1 -> the next cycle and all later cycles show halt 1, all enables 0, and pc_en 0, regardless of redirect or ihit activity.
- **Saturation.** Hold !ihit for 70000 cycles -> stall_cycles stops at 0xFFFF.
